// File: rtl/button_event_detector.sv
// Push-button front end: synchronise, debounce and classify into one-cycle event pulses.
// Define DOUBLE_CLICK_EN to add the double-click window (WAIT2 state, DCLICK_P output).
module button_event_detector #(
    parameter int DEBOUNCE_LIMIT = 120_000,
    parameter int LONG_LIMIT     = 6_000_000,
    parameter int DCLICK_LIMIT   = 3_600_000,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW2,
    output logic HELD,
    output logic PRESS_P,
    output logic RELEASE_P,
    output logic CLICK_P,
    output logic LONG_P,
    output logic DCLICK_P
);

    localparam int DW = $clog2(DEBOUNCE_LIMIT);
    localparam int HW = $clog2(LONG_LIMIT);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_LIMIT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_LIMIT - 1);

`ifdef DOUBLE_CLICK_EN
    localparam int WW = $clog2(DCLICK_LIMIT);
    localparam logic [WW-1:0] WIN_MAX = WW'(DCLICK_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG, WAIT2} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
`endif

    logic          sync1;
    logic          sync2;
    logic          pressed_sync;
    logic          stable;
    logic          stable_prev;
    logic [DW-1:0] db_cnt;
    logic          rise;
    logic          fall;

    state_t        state;
    state_t        state_n;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_n;
    logic          click_n;
    logic          long_n;

`ifdef DOUBLE_CLICK_EN
    logic          second;
    logic          second_n;
    logic [WW-1:0] win_cnt;
    logic [WW-1:0] win_n;
    logic          dclick_n;
`endif

    // Sync flops idle at the raw released level so reset never looks like a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= SW2;
            sync2 <= sync1;
        end
    end

    assign pressed_sync = sync2 ^ ACTIVE_LOW;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (pressed_sync == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
            stable <= ~stable;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stable_prev <= 1'b0;
        end else begin
            stable_prev <= stable;
        end
    end

    assign rise = stable & ~stable_prev;
    assign fall = ~stable & stable_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            hold_cnt <= '0;
`ifdef DOUBLE_CLICK_EN
            second   <= 1'b0;
            win_cnt  <= '0;
`endif
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
`ifdef DOUBLE_CLICK_EN
            second   <= second_n;
            win_cnt  <= win_n;
`endif
        end
    end

    // A release on the same cycle the hold limit is reached takes the short-press path.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        click_n = 1'b0;
        long_n  = 1'b0;
`ifdef DOUBLE_CLICK_EN
        second_n = second;
        win_n    = win_cnt;
        dclick_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = PRESSED;
                    hold_n  = '0;
`ifdef DOUBLE_CLICK_EN
                    second_n = 1'b0;
`endif
                end
            end
            PRESSED: begin
                if (fall) begin
`ifdef DOUBLE_CLICK_EN
                    if (second) begin
                        state_n = IDLE;
                    end else begin
                        state_n = WAIT2;
                        win_n   = '0;
                    end
`else
                    state_n = IDLE;
                    click_n = 1'b1;
`endif
                end else if (hold_cnt == HOLD_MAX) begin
                    state_n = LONG;
                    long_n  = 1'b1;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_n = IDLE;
                end
            end
`ifdef DOUBLE_CLICK_EN
            // At window expiry the pending click is emitted; a coincident press starts fresh.
            WAIT2: begin
                if (win_cnt == WIN_MAX) begin
                    click_n = 1'b1;
                    if (rise) begin
                        state_n  = PRESSED;
                        hold_n   = '0;
                        second_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (rise) begin
                    dclick_n = 1'b1;
                    state_n  = PRESSED;
                    hold_n   = '0;
                    second_n = 1'b1;
                end else begin
                    win_n = win_cnt + 1'b1;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            HELD      <= 1'b0;
            PRESS_P   <= 1'b0;
            RELEASE_P <= 1'b0;
            CLICK_P   <= 1'b0;
            LONG_P    <= 1'b0;
        end else begin
            HELD      <= stable;
            PRESS_P   <= rise;
            RELEASE_P <= fall;
            CLICK_P   <= click_n;
            LONG_P    <= long_n;
        end
    end

`ifdef DOUBLE_CLICK_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            DCLICK_P <= 1'b0;
        end else begin
            DCLICK_P <= dclick_n;
        end
    end
`else
    assign DCLICK_P = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_detector.sv
// Bench for button_event_detector: event-level reference model checked every cycle,
// plus directed scenarios with hand-computed pulse latencies.
module tb_button_event_detector;

    localparam int DEBOUNCE_LIMIT = 4;
    localparam int LONG_LIMIT     = 20;
    localparam int DCLICK_LIMIT   = 10;
    localparam bit ACTIVE_LOW     = 1'b0;

    logic CLK = 1'b0;
    logic RST;
    logic SW2;
    logic HELD;
    logic PRESS_P;
    logic RELEASE_P;
    logic CLICK_P;
    logic LONG_P;
    logic DCLICK_P;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    button_event_detector #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
        .LONG_LIMIT    (LONG_LIMIT),
        .DCLICK_LIMIT  (DCLICK_LIMIT),
        .ACTIVE_LOW    (ACTIVE_LOW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SW2      (SW2),
        .HELD     (HELD),
        .PRESS_P  (PRESS_P),
        .RELEASE_P(RELEASE_P),
        .CLICK_P  (CLICK_P),
        .LONG_P   (LONG_P),
        .DCLICK_P (DCLICK_P)
    );

    always #5 CLK = ~CLK;

    // Reference model: pressed-level history and event timestamps (edge numbers).
    bit hist[$];
    int k;
    bit st1;
    bit st2;
    bit exp_held, exp_press, exp_release, exp_click, exp_long, exp_dclick;
    bit in_press, long_done, second, wait_on;
    int press_edge, rel_edge;

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < DEBOUNCE_LIMIT + 2; j++) hist.push_back(1'b0);
        k = 0;
        st1 = 1'b0;
        st2 = 1'b0;
        exp_held = 0; exp_press = 0; exp_release = 0;
        exp_click = 0; exp_long = 0; exp_dclick = 0;
        in_press = 0; long_done = 0; second = 0; wait_on = 0;
        press_edge = 0; rel_edge = 0;
    endtask

    task automatic start_press(input bit is_second);
        in_press   = 1'b1;
        press_edge = k;
        long_done  = 1'b0;
        second     = is_second;
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            model_reset();
        end else begin
            int  n;
            bit  all_diff;
            k++;
            exp_held    = st1;
            exp_press   = st1 & ~st2;
            exp_release = ~st1 & st2;
            exp_click   = 1'b0;
            exp_long    = 1'b0;
            exp_dclick  = 1'b0;

            // Stable level flips once DEBOUNCE_LIMIT consecutive synchronised samples disagree.
            hist.push_back(SW2 ^ ACTIVE_LOW);
            n = hist.size();
            all_diff = 1'b1;
            for (int j = n - 2 - DEBOUNCE_LIMIT; j <= n - 3; j++)
                if (hist[j] == st1) all_diff = 1'b0;
            st2 = st1;
            if (all_diff) st1 = ~st1;
            if (hist.size() > 64) void'(hist.pop_front());

            if (exp_release && in_press) begin
                in_press = 1'b0;
                if (!long_done && !second) begin
`ifdef DOUBLE_CLICK_EN
                    wait_on  = 1'b1;
                    rel_edge = k;
`else
                    exp_click = 1'b1;
`endif
                end
            end else if (in_press && !long_done && (k - press_edge) == LONG_LIMIT) begin
                exp_long  = 1'b1;
                long_done = 1'b1;
            end

            if (exp_press) begin
                if (wait_on) begin
                    if (k - rel_edge < DCLICK_LIMIT) begin
                        exp_dclick = 1'b1;
                        start_press(1'b1);
                    end else begin
                        exp_click = 1'b1;
                        start_press(1'b0);
                    end
                    wait_on = 1'b0;
                end else begin
                    start_press(1'b0);
                end
            end else if (wait_on && (k - rel_edge) == DCLICK_LIMIT) begin
                exp_click = 1'b1;
                wait_on   = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            check_output("model_held",    HELD,      exp_held);
            check_output("model_press",   PRESS_P,   exp_press);
            check_output("model_release", RELEASE_P, exp_release);
            check_output("model_click",   CLICK_P,   exp_click);
            check_output("model_long",    LONG_P,    exp_long);
            check_output("model_dclick",  DCLICK_P,  exp_dclick);
        end
    end

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return HELD;
            1:       return PRESS_P;
            2:       return RELEASE_P;
            3:       return CLICK_P;
            4:       return LONG_P;
            default: return DCLICK_P;
        endcase
    endfunction

    // Measures negedges until the selected output goes high; -1 if it never does.
    task automatic wait_pulse(input string name, input int sel, input int expected_delay, input int max_cycles);
        int d = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge CLK);
            if (get_sig(sel)) begin
                d = i;
                break;
            end
        end
        check_int(name, d, expected_delay);
    endtask

    task automatic count_pulses(input int sel, input int cycles, output int count);
        count = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (get_sig(sel)) count++;
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic apply_stimulus(input bit level, input int cycles);
        SW2 = level;
        idle(cycles);
    endtask

    initial begin
        int cnt;
        RST = 1'b1;
        SW2 = 1'b0;
        @(posedge CLK);
        check_en = 1'b1;
        idle(3);
        check_output("reset_held",    HELD,      1'b0);
        check_output("reset_press",   PRESS_P,   1'b0);
        check_output("reset_release", RELEASE_P, 1'b0);
        check_output("reset_click",   CLICK_P,   1'b0);
        check_output("reset_long",    LONG_P,    1'b0);
        check_output("reset_dclick",  DCLICK_P,  1'b0);
        RST = 1'b0;
        idle(5);

        $display("[TB] clean short press");
        SW2 = 1'b1;
        wait_pulse("t1_press_delay", 1, 7, 20);
        check_output("t1_held_on_press", HELD, 1'b1);
        idle(3);
        SW2 = 1'b0;
        wait_pulse("t1_release_delay", 2, 7, 20);
        check_output("t1_held_off", HELD, 1'b0);
`ifdef DOUBLE_CLICK_EN
        check_output("t1_click_with_release", CLICK_P, 1'b0);
`else
        check_output("t1_click_with_release", CLICK_P, 1'b1);
`endif
        idle(30);

        $display("[TB] bouncing input");
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            SW2 = ((i / 2) % 2) == 0;
            @(negedge CLK);
            if (PRESS_P || RELEASE_P) cnt++;
        end
        check_int("t2_pulses_while_bouncing", cnt, 0);
        SW2 = 1'b1;
        wait_pulse("t2_press_after_settle", 1, 7, 20);
        idle(5);
        SW2 = 1'b0;
        idle(30);

        $display("[TB] long hold");
        SW2 = 1'b1;
        wait_pulse("t3_press_delay", 1, 7, 20);
        wait_pulse("t3_long_after_press", 4, 20, 40);
        count_pulses(4, 13, cnt);
        check_int("t3_extra_long_pulses", cnt, 0);
        SW2 = 1'b0;
        wait_pulse("t3_release_delay", 2, 7, 20);
        check_output("t3_no_click_after_long", CLICK_P, 1'b0);
        idle(30);

        $display("[TB] reset mid-press");
        SW2 = 1'b1;
        wait_pulse("t4_press_delay", 1, 7, 20);
        idle(2);
        check_output("t4_held_before_rst", HELD, 1'b1);
        RST = 1'b1;
        idle(1);
        check_output("t4_held_after_rst",    HELD,      1'b0);
        check_output("t4_press_after_rst",   PRESS_P,   1'b0);
        check_output("t4_release_after_rst", RELEASE_P, 1'b0);
        check_output("t4_long_after_rst",    LONG_P,    1'b0);
        RST = 1'b0;
        wait_pulse("t4_repress_delay", 1, 7, 20);
        check_output("t4_held_again", HELD, 1'b1);
        SW2 = 1'b0;
        idle(35);

`ifdef DOUBLE_CLICK_EN
        $display("[TB] double click");
        apply_stimulus(1'b1, 8);
        apply_stimulus(1'b0, 6);
        SW2 = 1'b1;
        wait_pulse("t5_dclick_delay", 5, 7, 20);
        check_output("t5_press_with_dclick", PRESS_P, 1'b1);
        idle(1);
        SW2 = 1'b0;
        count_pulses(3, 30, cnt);
        check_int("t5_clicks", cnt, 0);

        $display("[TB] single click with window");
        apply_stimulus(1'b1, 8);
        SW2 = 1'b0;
        wait_pulse("t6_release_delay", 2, 7, 20);
        wait_pulse("t6_click_after_release", 3, 10, 20);
        idle(20);
`endif

        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
